// File: rtl/lvds_spi_pkg.sv
// Shared types and default parameters for the LVDS SPI capture receiver.
package lvds_spi_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_FIFO_DEPTH  = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } rx_state_e;

endpackage

// File: rtl/lvds_spi_fifo.sv
// First-word-fall-through FIFO; pointers carry one extra wrap bit so full and
// empty can be told apart when the index bits match.
module lvds_spi_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_L,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic             rd_en;

  // Full comes from the registered pointers, so a same-cycle pop never frees
  // room for the incoming word.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign drop  = push & full;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define validity, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/lvds_spi_rx_deser.sv
// LVDS SPI receive deserializer: synchronizes scl_del/sdi/cs_n, packs bits
// MSB-first into words and streams them out through a FWFT FIFO.
module lvds_spi_rx_deser
  import lvds_spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst_L,
  input  logic                  scl_del,
  input  logic                  sdi,
  input  logic                  cs_n,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  overflow,
  output logic                  frame_err,
  input  logic                  clr_err
);

  localparam int unsigned   CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,  cs_sync_d;
  logic                   scl_dly_q,  scl_dly_d;
  logic                   cs_dly_q,   cs_dly_d;
  logic                   s_scl, s_sdi, s_cs;
  logic                   scl_rise, cs_rise;

  rx_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d, shift_next;
  logic [CW-1:0]          bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-1:0]  pend_q, pend_d;
  logic                   pend_valid_q, pend_valid_d;
  logic                   push_q, push_d;
  logic [DATA_WIDTH-1:0]  push_data_q, push_data_d;
  logic                   push_last_q, push_last_d;
  logic                   overflow_q, overflow_d;
  logic                   frame_err_q, frame_err_d;
  logic                   frame_err_set;

  logic [DATA_WIDTH:0]    fifo_head;
  logic                   fifo_full, fifo_empty, fifo_drop;

  // Equal-depth chains keep sdi and cs_n aligned with the scl edge they belong to.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_del};
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0],  cs_n};
    scl_dly_d  = s_scl;
    cs_dly_d   = s_cs;
  end

  assign s_scl    = scl_sync_q[SYNC_STAGES-1];
  assign s_sdi    = sdi_sync_q[SYNC_STAGES-1];
  assign s_cs     = cs_sync_q[SYNC_STAGES-1];
  assign scl_rise = s_scl & ~scl_dly_q;
  assign cs_rise  = s_cs & ~cs_dly_q;

  // cs_n resets to "selected" so a frame already in flight must be seen to end first.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      scl_sync_q <= '0;
      sdi_sync_q <= '0;
      cs_sync_q  <= '0;
      scl_dly_q  <= 1'b0;
      cs_dly_q   <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sdi_sync_q <= sdi_sync_d;
      cs_sync_q  <= cs_sync_d;
      scl_dly_q  <= scl_dly_d;
      cs_dly_q   <= cs_dly_d;
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) state_q <= WAIT_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_IDLE: if (s_cs)    state_d = IDLE;
      IDLE:      if (!s_cs)   state_d = ACTIVE;
      ACTIVE:    if (cs_rise) state_d = IDLE;
      default:                state_d = WAIT_IDLE;
    endcase
  end

  // A completed word waits in pend until the next word completes, so a frame
  // ending on a partial word can still mark its last whole word.
  always_comb begin
    shift_next    = {shift_q[DATA_WIDTH-2:0], s_sdi};
    shift_d       = shift_q;
    bitcnt_d      = bitcnt_q;
    pend_d        = pend_q;
    pend_valid_d  = pend_valid_q;
    push_d        = 1'b0;
    push_data_d   = push_data_q;
    push_last_d   = push_last_q;
    frame_err_set = 1'b0;
    unique case (state_q)
      ACTIVE: begin
        if (cs_rise) begin
          if (pend_valid_q) begin
            push_d      = 1'b1;
            push_data_d = pend_q;
            push_last_d = 1'b1;
          end
          pend_valid_d  = 1'b0;
          bitcnt_d      = '0;
          frame_err_set = (bitcnt_q != '0);
        end else if (scl_rise) begin
          shift_d = shift_next;
          if (bitcnt_q == LAST_BIT) begin
            if (pend_valid_q) begin
              push_d      = 1'b1;
              push_data_d = pend_q;
              push_last_d = 1'b0;
            end
            pend_d       = shift_next;
            pend_valid_d = 1'b1;
            bitcnt_d     = '0;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      default: begin
        bitcnt_d     = '0;
        pend_valid_d = 1'b0;
      end
    endcase
  end

  // A set event in the same cycle as clr_err leaves the flag set.
  always_comb begin
    overflow_d  = (overflow_q  & ~clr_err) | fifo_drop;
    frame_err_d = (frame_err_q & ~clr_err) | frame_err_set;
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      shift_q      <= '0;
      bitcnt_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      push_last_q  <= 1'b0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      bitcnt_q     <= bitcnt_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      push_last_q  <= push_last_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
    end
  end

  lvds_spi_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_L     (rst_L),
    .push      (push_q),
    .push_data ({push_last_q, push_data_q}),
    .pop       (m_tready & ~fifo_empty),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  // Masking the head while empty keeps the unreset storage off the port.
  assign m_tvalid  = ~fifo_empty;
  assign m_tdata   = fifo_empty ? '0   : fifo_head[DATA_WIDTH-1:0];
  assign m_tlast   = fifo_empty ? 1'b0 : fifo_head[DATA_WIDTH];
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_lvds_spi_rx_deser.sv
// Directed bench for lvds_spi_rx_deser: bit-bangs SPI frames and checks the
// captured stream beats and sticky flags against hand-computed values.
module tb_lvds_spi_rx_deser;

  logic        clk;
  logic        rst_L;
  logic        scl_del;
  logic        sdi;
  logic        cs_n;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        overflow;
  logic        frame_err;
  logic        clr_err;

  int          vectors;
  int          miscompares;
  logic [32:0] beats [$];
  logic [31:0] ovf_words [9];

  lvds_spi_rx_deser dut (
    .clk       (clk),
    .rst_L     (rst_L),
    .scl_del   (scl_del),
    .sdi       (sdi),
    .cs_n      (cs_n),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clr_err   (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted beat as {last, data}, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_L && m_tvalid && m_tready) beats.push_back({m_tlast, m_tdata});
  end

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    sdi     = b;
    scl_del = 1'b0;
    tick(3);
    scl_del = 1'b1;
    tick(3);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic start_frame();
    cs_n = 1'b0;
    tick(4);
  endtask

  task automatic end_frame();
    scl_del = 1'b0;
    tick(3);
    cs_n = 1'b1;
    tick(12);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_L    = 1'b0;
    scl_del  = 1'b0;
    sdi      = 1'b0;
    cs_n     = 1'b1;
    m_tready = 1'b1;
    clr_err  = 1'b0;
    for (int i = 0; i < 9; i++) ovf_words[i] = {8'(i + 1), 24'hC0FFEE};

    // Reset values
    tick(3);
    check("rst_tdata",     {1'b0, m_tdata}, 33'h0);
    check("rst_tvalid",    33'(m_tvalid),   33'h0);
    check("rst_tlast",     33'(m_tlast),    33'h0);
    check("rst_overflow",  33'(overflow),   33'h0);
    check("rst_frame_err", 33'(frame_err),  33'h0);
    rst_L = 1'b1;
    tick(8);

    // Basic two-word frame
    beats.delete();
    start_frame();
    send_bits(32'hA5A50F0F, 32);
    send_bits(32'h12345678, 32);
    end_frame();
    check("basic_count", 33'(beats.size()), 33'd2);
    check("basic_beat0", beats[0], {1'b0, 32'hA5A50F0F});
    check("basic_beat1", beats[1], {1'b1, 32'h12345678});
    check("basic_overflow",  33'(overflow),  33'h0);
    check("basic_frame_err", 33'(frame_err), 33'h0);

    // Latency: m_tvalid rises on the 4th clk edge after the cs_n pin rise
    m_tready = 1'b0;
    start_frame();
    send_bits(32'hDEADBEEF, 32);
    scl_del = 1'b0;
    tick(3);
    cs_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("lat_tvalid_3", 33'(m_tvalid), 33'h0);
    @(posedge clk);
    @(negedge clk);
    check("lat_tvalid_4", 33'(m_tvalid), 33'h1);
    check("lat_head", {m_tlast, m_tdata}, {1'b1, 32'hDEADBEEF});
    tick(1);
    m_tready = 1'b1;
    tick(4);
    check("lat_drained", 33'(m_tvalid), 33'h0);

    // Overflow: nine words with the consumer stalled
    m_tready = 1'b0;
    start_frame();
    for (int i = 0; i < 9; i++) send_bits(ovf_words[i], 32);
    end_frame();
    check("ovf_flag",   33'(overflow), 33'h1);
    check("ovf_head",   {m_tlast, m_tdata}, {1'b0, 32'h01C0FFEE});
    beats.delete();
    m_tready = 1'b1;
    tick(12);
    check("ovf_count",  33'(beats.size()), 33'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("ovf_beat%0d", i), beats[i], {1'b0, ovf_words[i]});
    check("ovf_empty",  33'(m_tvalid), 33'h0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(1);
    check("ovf_cleared", 33'(overflow), 33'h0);

    // Partial word: 40-bit frame
    beats.delete();
    start_frame();
    send_bits(32'h13579BDF, 32);
    send_bits(32'h000000AA, 8);
    end_frame();
    check("part_count", 33'(beats.size()), 33'd1);
    check("part_beat0", beats[0], {1'b1, 32'h13579BDF});
    check("part_frame_err", 33'(frame_err), 33'h1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(1);
    check("part_cleared", 33'(frame_err), 33'h0);

    // clr_err in the same cycle as a new frame_err event
    beats.delete();
    start_frame();
    send_bits(32'h0000000B, 4);
    scl_del = 1'b0;
    tick(3);
    cs_n = 1'b1;
    tick(2);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("coll_frame_err", 33'(frame_err), 33'h1);
    tick(4);
    check("coll_no_beats", 33'(beats.size()), 33'd0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(1);
    check("coll_lone_clear", 33'(frame_err), 33'h0);

    // Reset mid-frame with a word already queued
    m_tready = 1'b0;
    start_frame();
    send_bits(32'h11111111, 32);
    send_bits(32'h22222222, 32);
    send_bits(32'h00003333, 16);
    check("rmid_queued", 33'(m_tvalid), 33'h1);
    rst_L = 1'b0;
    #1;
    check("rmid_async_clear", 33'(m_tvalid), 33'h0);
    tick(2);
    rst_L = 1'b1;
    beats.delete();
    m_tready = 1'b1;
    send_bits(32'h00004444, 16);
    send_bits(32'h55555555, 32);
    scl_del = 1'b0;
    tick(6);
    check("rmid_ignored", 33'(beats.size()), 33'd0);
    cs_n = 1'b1;
    tick(8);
    check("rmid_cs_high", 33'(beats.size()), 33'd0);
    start_frame();
    send_bits(32'h0BADF00D, 32);
    end_frame();
    check("rmid_count", 33'(beats.size()), 33'd1);
    check("rmid_beat0", beats[0], {1'b1, 32'h0BADF00D});
    check("rmid_frame_err", 33'(frame_err), 33'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
